ddr3_ddrphy_rx_dq_align: RTL

//  Read-side word aligner for one DDR3 PHY lane bit. Counterpart of the TX-only command/address IODs.

---
 rtl/ddr3_ddrphy_rx_dq_align.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ddr3_ddrphy_rx_dq_align.sv
// ============================================================================
//  Module   : ddr3_ddrphy_rx_dq_align
//  Purpose  : Read-training word aligner for one DDR3 DQ lane bit; steers the
//             RX IOD with bit-slip and delay-line steps until the pattern locks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_ddrphy_rx_dq_align #(
    parameter int                  RX_WIDTH      = 4,
    parameter logic [RX_WIDTH-1:0] TRAIN_PATTERN = 4'b0011,
    parameter int                  MATCH_COUNT   = 8,
    parameter int                  SETTLE_CYCLES = 4,
    parameter int                  MAX_DLY_STEPS = 64
) (
    input  logic                        FAB_CLK,
    input  logic                        RX_SYNC_RST,
    input  logic                        TRAIN_START,
    input  logic [RX_WIDTH-1:0]         RX_DATA_IN,
    input  logic                        DELAY_LINE_OUT_OF_RANGE,
    output logic                        RX_BIT_SLIP,
    output logic                        DELAY_LINE_LOAD,
    output logic                        DELAY_LINE_MOVE,
    output logic                        DELAY_LINE_DIRECTION,
    output logic [RX_WIDTH-1:0]         RX_DATA_OUT,
    output logic                        RX_DATA_VALID,
    output logic                        TRAIN_DONE,
    output logic                        TRAIN_FAIL,
    output logic [$clog2(RX_WIDTH)-1:0] SLIP_POS,
    output logic [7:0]                  DLY_STEP_COUNT
);

    localparam int TW = $clog2(RX_WIDTH);
    localparam int MW = $clog2(MATCH_COUNT + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [TW-1:0] C_TRY_LAST    = TW'(RX_WIDTH - 1);
    localparam logic [MW-1:0] C_MATCH_LAST  = MW'(MATCH_COUNT - 1);
    localparam logic [SW-1:0] C_SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [7:0]    C_MAX_STEPS   = 8'(MAX_DLY_STEPS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_SLIP   = 3'd4,
        S_STEP   = 3'd5,
        S_DONE   = 3'd6,
        S_FAIL   = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic                slip_q, slip_d;
    logic                load_q, load_d;
    logic                move_q, move_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;
    logic                valid_q, valid_d;
    logic [RX_WIDTH-1:0] data_q, data_d;
    logic [TW-1:0]       slip_pos_q, slip_pos_d;
    logic [7:0]          dly_cnt_q, dly_cnt_d;
    logic [TW-1:0]       try_cnt_q, try_cnt_d;
    logic [MW-1:0]       match_cnt_q, match_cnt_d;
    logic [SW-1:0]       settle_cnt_q, settle_cnt_d;

    always_comb begin
        state_d      = state_q;
        slip_d       = 1'b0;
        load_d       = 1'b0;
        move_d       = 1'b0;
        done_d       = done_q;
        fail_d       = fail_q;
        data_d       = RX_DATA_IN;
        slip_pos_d   = slip_pos_q;
        dly_cnt_d    = dly_cnt_q;
        try_cnt_d    = try_cnt_q;
        match_cnt_d  = match_cnt_q;
        settle_cnt_d = settle_cnt_q;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (TRAIN_START) begin
                    state_d     = S_LOAD;
                    load_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    slip_pos_d  = '0;
                    dly_cnt_d   = '0;
                    try_cnt_d   = '0;
                    match_cnt_d = '0;
                end
            end
            S_LOAD: begin
                state_d      = S_SETTLE;
                settle_cnt_d = '0;
            end
            S_SETTLE: begin
                if (settle_cnt_q == C_SETTLE_LAST) begin
                    state_d     = S_CHECK;
                    match_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (RX_DATA_IN == TRAIN_PATTERN) begin
                    match_cnt_d = match_cnt_q + 1'b1;
                    if (match_cnt_q == C_MATCH_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    match_cnt_d = '0;
                    // All word rotations tried at this delay tap: move the tap instead.
                    if (try_cnt_q != C_TRY_LAST) begin
                        state_d    = S_SLIP;
                        slip_d     = 1'b1;
                        try_cnt_d  = try_cnt_q + 1'b1;
                        slip_pos_d = (slip_pos_q == C_TRY_LAST) ? '0 : slip_pos_q + 1'b1;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_SLIP: begin
                state_d      = S_SETTLE;
                settle_cnt_d = '0;
            end
            S_STEP: begin
                if (DELAY_LINE_OUT_OF_RANGE || (dly_cnt_q == C_MAX_STEPS)) begin
                    state_d = S_FAIL;
                    fail_d  = 1'b1;
                end else begin
                    state_d      = S_SETTLE;
                    move_d       = 1'b1;
                    dly_cnt_d    = dly_cnt_q + 1'b1;
                    try_cnt_d    = '0;
                    settle_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            state_q      <= S_IDLE;
            slip_q       <= 1'b0;
            load_q       <= 1'b0;
            move_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            slip_pos_q   <= '0;
            dly_cnt_q    <= '0;
            try_cnt_q    <= '0;
            match_cnt_q  <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            slip_q       <= slip_d;
            load_q       <= load_d;
            move_q       <= move_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            slip_pos_q   <= slip_pos_d;
            dly_cnt_q    <= dly_cnt_d;
            try_cnt_q    <= try_cnt_d;
            match_cnt_q  <= match_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign RX_BIT_SLIP          = slip_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign DELAY_LINE_DIRECTION = move_q;
    assign RX_DATA_OUT          = data_q;
    assign RX_DATA_VALID        = valid_q;
    assign TRAIN_DONE           = done_q;
    assign TRAIN_FAIL           = fail_q;
    assign SLIP_POS             = slip_pos_q;
    assign DLY_STEP_COUNT       = dly_cnt_q;

endmodule

`default_nettype wire
